// File: rtl/relu32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : relu32_pkg
// Description : Shared geometry and state encoding for the relu32 output path.
// Revision    : 1.0 - initial release
// ============================================================================
package relu32_pkg;

    localparam int N_LANES    = 32;
    localparam int IN_W       = 7;
    localparam int OUT_W      = 8;
    localparam int BEAT_LANES = 4;
    localparam int N_BEATS    = N_LANES / BEAT_LANES;
    localparam int BEAT_W     = $clog2(N_BEATS);
    localparam int VEC_W      = N_LANES * IN_W;
    localparam int BEAT_DW    = BEAT_LANES * OUT_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage : relu32_pkg
`default_nettype wire

// File: rtl/relu32_beat_select.sv
`default_nettype none
// ============================================================================
// Module      : relu32_beat_select
// Description : Picks one beat of lanes from the packed vector, zero-extended.
// Revision    : 1.0 - initial release
// ============================================================================
module relu32_beat_select
    import relu32_pkg::*;
(
    input  logic [VEC_W-1:0]   vec_i,
    input  logic [BEAT_W-1:0]  beat_i,
    output logic [BEAT_DW-1:0] data_o
);

    logic [IN_W-1:0] w_lanes [N_BEATS][BEAT_LANES];

    for (genvar b = 0; b < N_BEATS; b++) begin : g_beat
        for (genvar k = 0; k < BEAT_LANES; k++) begin : g_lane
            assign w_lanes[b][k] = vec_i[(b*BEAT_LANES + k)*IN_W +: IN_W];
        end
    end

    for (genvar k = 0; k < BEAT_LANES; k++) begin : g_out
        assign data_o[k*OUT_W +: OUT_W] = {{(OUT_W-IN_W){1'b0}}, w_lanes[beat_i][k]};
    end

endmodule : relu32_beat_select
`default_nettype wire

// File: rtl/relu32_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : relu32_out_serializer
// Description : Accepts a packed 32x7b vector and streams it as 8b-lane beats.
// Revision    : 1.0 - initial release
// ============================================================================
module relu32_out_serializer
    import relu32_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VEC_W-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BEAT_DW-1:0] out_data,
    output logic               out_last,
    output logic               busy
);

    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(N_BEATS - 1);

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [BEAT_DW-1:0] out_data_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic               busy_q;
    logic               w_last;
    logic [BEAT_DW-1:0] w_beat_data;

    assign w_last   = (beat_q == C_LAST_BEAT);
    // Accepting on the final beat lets the next vector follow without a bubble.
    assign in_ready = (state_q == IDLE) || ((state_q == SEND) && out_ready && w_last);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        vec_d   = vec_q;
        if (in_valid && in_ready) begin
            vec_d   = in_data;
            beat_d  = '0;
            state_d = SEND;
        end else if ((state_q == SEND) && out_ready) begin
            if (w_last) begin
                beat_d  = '0;
                state_d = IDLE;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    // Beat is formed from next-state so the output register lines up with beat_q.
    relu32_beat_select u_beat_select (
        .vec_i  (vec_d),
        .beat_i (beat_d),
        .data_o (w_beat_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            vec_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            vec_q       <= vec_d;
            out_data_q  <= w_beat_data;
            out_valid_q <= (state_d == SEND);
            out_last_q  <= (state_d == SEND) && (beat_d == C_LAST_BEAT);
            busy_q      <= (state_d == SEND);
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule : relu32_out_serializer
`default_nettype wire

// File: tb/tb_relu32_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_relu32_out_serializer
// Description : Scoreboard bench with a lane-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu32_out_serializer;

    localparam int NL = 32;
    localparam int IW = 7;
    localparam int OW = 8;
    localparam int BL = 4;
    localparam int NB = NL / BL;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NL*IW-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [BL*OW-1:0] out_data;
    logic             out_last;
    logic             busy;

    relu32_out_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    acc_cyc = 0;
    bit    rnd_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: beat b is lanes b*BL.. packed as zero-extended bytes, low lane first.
    function automatic logic [31:0] model_beat(input logic [NL*IW-1:0] v, input int b);
        logic [31:0]      w;
        logic [NL*IW-1:0] s;
        w = '0;
        for (int k = 0; k < BL; k++) begin
            s = v >> ((b*BL + k) * IW);
            w = w | (32'(s[IW-1:0]) << (OW*k));
        end
        return w;
    endfunction

    function automatic logic [NL*IW-1:0] make_id(input int base);
        logic [NL*IW-1:0] v;
        v = '0;
        for (int i = 0; i < NL; i++) v[i*IW +: IW] = IW'(base + i);
        return v;
    endfunction

    function automatic logic [NL*IW-1:0] make_rnd();
        logic [NL*IW-1:0] v;
        v = '0;
        for (int i = 0; i < NL; i++) v[i*IW +: IW] = IW'($urandom);
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor / scoreboard
    initial begin : monitor
        logic        pv, pr, pl;
        logic [31:0] pd;
        beat_t       e;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", out_data, pd);
                    check("stall_last", 32'(out_last), 32'(pl));
                end
                check("out_valid", 32'(out_valid), 32'(q.size() != 0));
                check("busy", 32'(busy), 32'(q.size() != 0));
                check("in_ready", 32'(in_ready),
                      32'((q.size() == 0) || (out_ready && q.size() == 1)));
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("beat_data", out_data, e.data);
                        check("beat_last", 32'(out_last), 32'(e.last));
                    end
                end
                if (in_valid && in_ready) begin
                    for (int b = 0; b < NB; b++) begin
                        e.data = model_beat(in_data, b);
                        e.last = (b == NB-1);
                        q.push_back(e);
                    end
                end
                pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            end
        end
    end

    task automatic send_vec(input logic [NL*IW-1:0] v);
        bit ok;
        ok = 1'b0;
        in_data  = v;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_q(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (q.size() == n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_q_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_empty(output int ec);
        bit ok;
        ok = 1'b0;
        ec = cyc;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0 && !out_valid) begin
                ec = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [NL*IW-1:0] v;
        int ec, a0;

        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Lane identity
        send_vec(make_id(0));
        check("id_beat0", out_data, 32'h03020100);
        wait_empty(ec);
        check("id_cycles", 32'(ec - acc_cyc), 32'd8);

        // All-max lanes
        v = '1;
        send_vec(v);
        check("max_beat0", out_data, 32'h7F7F7F7F);
        wait_empty(ec);

        // Backpressure at beat 2
        send_vec(make_id(0));
        wait_q(6);
        out_ready = 1'b0;
        check("bp_beat2", out_data, 32'h0B0A0908);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_empty(ec);
        check("bp_cycles", 32'(ec - acc_cyc), 32'd11);

        // Back-to-back A then B
        send_vec(make_id(0));
        a0 = acc_cyc;
        send_vec(make_id(8'h40));
        check("b2b_accept_gap", 32'(acc_cyc - a0), 32'd8);
        check("b2b_b_beat0", out_data, 32'h43424140);
        wait_empty(ec);
        check("b2b_cycles", 32'(ec - a0), 32'd16);

        // New input during SEND must be ignored
        send_vec(make_id(0));
        wait_q(4);
        in_data  = make_rnd();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_empty(ec);
        check("ign_cycles", 32'(ec - acc_cyc), 32'd8);

        // Reset mid-vector at beat 3
        send_vec(make_id(0));
        wait_q(5);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out_last", 32'(out_last), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        v = make_rnd();
        send_vec(v);
        check("mrst_restart_beat0", out_data, model_beat(v, 0));
        wait_empty(ec);

        // Randomized traffic with random backpressure and gaps
        rnd_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            send_vec(make_rnd());
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        @(posedge clk);
        rnd_ready = 1'b0;
        #2 out_ready = 1'b1;
        wait_empty(ec);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_relu32_out_serializer
`default_nettype wire
